fma_align_ctrl: RTL

//  FP32 FMA front-end stage (R = +/-A*B +/- C); sits directly upstream of align_shf_74.

---
 rtl/fma_pkg.sv | 52 +++++
 rtl/fp32_unpack.sv | 38 +++
 rtl/fma_align_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared FP32 field widths, FMA alignment constants and payload types for the
// FMA front-end. Top and unpack submodule honour the FMA_DENORM_EN macro.
package fma_pkg;

   // FP32 word layout
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned SIG_W   = MAN_W + 1;
   localparam int unsigned EXP_MAX = 255;

   // Alignment constants
   localparam int unsigned BIAS     = 127;
   localparam int unsigned PROD_OFS = 27;
   localparam int unsigned SHF_MAX  = 74;

   // Derived datapath widths
   localparam int unsigned SHF_W  = 7;
   localparam int unsigned EB_W   = 10;
   localparam int unsigned D_W    = 11;
   localparam int unsigned FLAG_W = 4;

   // spec_flags bit positions
   localparam int unsigned FLG_NAN   = 3;
   localparam int unsigned FLG_INF   = 2;
   localparam int unsigned FLG_PZERO = 1;
   localparam int unsigned FLG_CZERO = 0;

   // One unpacked FP32 operand
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp_eff;
      logic [SIG_W-1:0] sig;
      logic             is_nan;
      logic             is_inf;
      logic             is_zero;
   } fp_unp_t;

   // Stage-1 payload: unpacked operands plus the unclamped shift
   typedef struct packed {
      logic [SIG_W-1:0]  a_sig;
      logic [SIG_W-1:0]  b_sig;
      logic [SIG_W-1:0]  c_sig;
      logic              prod_sign;
      logic              inv_mask;
      logic [D_W-1:0]    shf_raw;
      logic [EB_W-1:0]   exp_c;
      logic [EB_W-1:0]   exp_prod;
      logic [FLAG_W-1:0] flags;
   } s1_pay_t;

endpackage

// File: rtl/fp32_unpack.sv
// FP32 unpacker: sign, effective exponent, significand with hidden bit and
// class flags. FMA_DENORM_EN keeps subnormals; otherwise they flush to zero.
import fma_pkg::*;

module fp32_unpack (
   input  logic [WORD_W-1:0] word,
   output fp_unp_t           unp_c
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   logic             exp_zero;
   logic             exp_ones;
   logic             man_zero;

   assign exp_f    = word[WORD_W-2 -: EXP_W];
   assign man_f    = word[MAN_W-1:0];
   assign exp_zero = (exp_f == '0);
   assign exp_ones = (exp_f == EXP_W'(EXP_MAX));
   assign man_zero = (man_f == '0);

   // Field split and classification; a zero exponent field still counts as e=1
   always_comb begin
      unp_c         = '0;
      unp_c.sign    = word[WORD_W-1];
      unp_c.exp_eff = exp_zero ? EXP_W'(1) : exp_f;
      unp_c.is_nan  = exp_ones & ~man_zero;
      unp_c.is_inf  = exp_ones & man_zero;
`ifdef FMA_DENORM_EN
      unp_c.sig     = {~exp_zero, man_f};
      unp_c.is_zero = exp_zero & man_zero;
`else
      unp_c.sig     = exp_zero ? '0 : {1'b1, man_f};
      unp_c.is_zero = exp_zero;
`endif
   end

endmodule

// File: rtl/fma_align_ctrl.sv
// FP32 FMA front-end: unpacks A/B/C, computes the addend right shift and the
// effective-subtract flag for the downstream aligner. Two-stage valid/ready
// pipeline. Subnormal handling selected by FMA_DENORM_EN (undefined = DAZ).
import fma_pkg::*;

module fma_align_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_op,
   input  logic [WORD_W-1:0] b_op,
   input  logic [WORD_W-1:0] c_op,
   input  logic              neg_prod,
   input  logic              sub_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SHF_W-1:0]  shf_num,
   output logic              inv_mask,
   output logic [SIG_W-1:0]  c_frac,
   output logic [SIG_W-1:0]  a_frac,
   output logic [SIG_W-1:0]  b_frac,
   output logic              prod_sign,
   output logic [EB_W-1:0]   exp_base,
   output logic [FLAG_W-1:0] spec_flags
);

   fp_unp_t          ua_c;
   fp_unp_t          ub_c;
   fp_unp_t          uc_c;
   s1_pay_t          s1_d_c;
   s1_pay_t          s1_q;
   logic             s1_v;
   logic             s2_v;
   logic             s2_adv_c;
   logic             s1_ld_c;
   logic [SHF_W-1:0] shf_c;
   logic [EB_W-1:0]  base_c;

   fp32_unpack u_unp_a (.word(a_op), .unp_c(ua_c));
   fp32_unpack u_unp_b (.word(b_op), .unp_c(ub_c));
   fp32_unpack u_unp_c (.word(c_op), .unp_c(uc_c));

   // Handshake: a stage advances when its successor is empty or advancing
   assign s2_adv_c  = s1_v & (~s2_v | out_ready);
   assign in_ready  = ~s1_v | s2_adv_c;
   assign s1_ld_c   = in_valid & in_ready & ~flush;
   assign out_valid = s2_v;

   // Stage-1 datapath: signs, flags and the signed, unclamped shift amount
   always_comb begin
      s1_d_c                    = '0;
      s1_d_c.a_sig              = ua_c.sig;
      s1_d_c.b_sig              = ub_c.sig;
      s1_d_c.c_sig              = uc_c.sig;
      s1_d_c.prod_sign          = ua_c.sign ^ ub_c.sign ^ neg_prod;
      s1_d_c.inv_mask           = ua_c.sign ^ ub_c.sign ^ uc_c.sign ^ neg_prod ^ sub_c;
      s1_d_c.shf_raw            = D_W'(ua_c.exp_eff) + D_W'(ub_c.exp_eff) + D_W'(PROD_OFS)
                                  - D_W'(BIAS) - D_W'(uc_c.exp_eff);
      s1_d_c.exp_c              = EB_W'(uc_c.exp_eff);
      s1_d_c.exp_prod           = EB_W'(ua_c.exp_eff) + EB_W'(ub_c.exp_eff) + EB_W'(PROD_OFS)
                                  - EB_W'(BIAS);
      s1_d_c.flags[FLG_NAN]     = ua_c.is_nan | ub_c.is_nan | uc_c.is_nan;
      s1_d_c.flags[FLG_INF]     = ua_c.is_inf | ub_c.is_inf | uc_c.is_inf;
      s1_d_c.flags[FLG_PZERO]   = ua_c.is_zero | ub_c.is_zero;
      s1_d_c.flags[FLG_CZERO]   = uc_c.is_zero;
   end

   // Stage-2 datapath: clamp shift to 0..SHF_MAX and pick the exponent reference
   always_comb begin
      shf_c  = '0;
      base_c = s1_q.exp_c;
      if (s1_q.shf_raw[D_W-1] || (s1_q.shf_raw == '0)) begin
         shf_c  = '0;
         base_c = s1_q.exp_c;
      end else if (s1_q.shf_raw >= D_W'(SHF_MAX)) begin
         shf_c  = SHF_W'(SHF_MAX);
         base_c = s1_q.exp_prod;
      end else begin
         shf_c  = SHF_W'(s1_q.shf_raw);
         base_c = s1_q.exp_prod;
      end
   end

   // Stage-1 register; flush empties it and blocks acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_q <= '0;
      end else begin
         if (flush) begin
            s1_v <= 1'b0;
         end else if (in_ready) begin
            s1_v <= in_valid;
         end
         if (s1_ld_c) begin
            s1_q <= s1_d_c;
         end
      end
   end

   // Stage-2 (output) register; data holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v       <= 1'b0;
         shf_num    <= '0;
         inv_mask   <= 1'b0;
         c_frac     <= '0;
         a_frac     <= '0;
         b_frac     <= '0;
         prod_sign  <= 1'b0;
         exp_base   <= '0;
         spec_flags <= '0;
      end else begin
         if (flush) begin
            s2_v <= 1'b0;
         end else if (~s2_v | out_ready) begin
            s2_v <= s1_v;
         end
         if (s2_adv_c & ~flush) begin
            shf_num    <= shf_c;
            inv_mask   <= s1_q.inv_mask;
            c_frac     <= s1_q.c_sig;
            a_frac     <= s1_q.a_sig;
            b_frac     <= s1_q.b_sig;
            prod_sign  <= s1_q.prod_sign;
            exp_base   <= base_c;
            spec_flags <= s1_q.flags;
         end
      end
   end

endmodule
